abus_cmd_queue: RTL and testbench



---
 rtl/abus_cmd_queue_pkg.sv | 25 ++
 rtl/abus_cmd_queue_if.sv | 38 +++
 rtl/abus_sync_fifo.sv | 46 ++++
 rtl/abus_cmd_queue.sv | 156 +++++++++++++++
 tb/tb_abus_cmd_queue.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/abus_cmd_queue_pkg.sv
// Shared encodings for the abus command queue: FSM states and response status codes.
// Status 2'b11 is reserved and never produced.
package abus_cmd_queue_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_ABORT,
    ST_ABWAIT,
    ST_RESP
  } state_t;

  typedef enum logic [1:0] {
    RSP_OK         = 2'b00,
    RSP_TIMEOUT    = 2'b01,
    RSP_RETRIED_OK = 2'b10,
    RSP_RSVD       = 2'b11
  } status_t;

  function automatic status_t done_status(input logic retried);
    return retried ? RSP_RETRIED_OK : RSP_OK;
  endfunction

endpackage

// File: rtl/abus_cmd_queue_if.sv
// Client command/response port plus master order port of the abus command queue.
// slave = the queue itself, master = the client/master environment driving it.
interface abus_cmd_queue_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [1:0]            rsp_status;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  mst_write;
  logic                  mst_read;
  logic                  mst_abort;
  logic [ADDR_WIDTH-1:0] mst_address;
  logic [DATA_WIDTH-1:0] mst_wdata;
  logic [DATA_WIDTH-1:0] mst_rdata;
  logic                  mst_new_rdata;
  logic                  mst_done;

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
           mst_rdata, mst_new_rdata, mst_done,
    output cmd_ready, rsp_valid, rsp_status, rsp_rdata,
           mst_write, mst_read, mst_abort, mst_address, mst_wdata
  );

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
           mst_rdata, mst_new_rdata, mst_done,
    input  cmd_ready, rsp_valid, rsp_status, rsp_rdata,
           mst_write, mst_read, mst_abort, mst_address, mst_wdata
  );
endinterface

// File: rtl/abus_sync_fifo.sv
// Generic synchronous FIFO with full/empty flags; head word is readable combinationally.
// Latency: a pushed word is visible at the head one cycle later.
// Backpressure: pushes while full and pops while empty are ignored.
module abus_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer MSB tells full from empty when the index bits match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign pop_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/abus_cmd_queue.sv
// Buffers client commands, issues them to the abus master one at a time, aborts on timeout, returns one response each.
// Latency: k+3 cycles accept-to-rsp_valid (empty FIFO, done k cycles after issue). Retry after abort: ABUS_CMD_QUEUE_RETRY_EN.
// Backpressure: cmd_ready = FIFO not full; a response held by rsp_ready low stalls further issue.
module abus_cmd_queue
  import abus_cmd_queue_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 64,
  parameter int MAX_RETRY  = 2
) (
  input logic             abus_clk,
  input logic             abus_rst,
  abus_cmd_queue_if.slave bus
);
  localparam int CMD_W = 1 + ADDR_WIDTH + DATA_WIDTH;
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
`ifdef ABUS_CMD_QUEUE_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif

  state_t                state, state_nxt;
  status_t               status_q, status_nxt;
  logic                  wr_q, wr_nxt;
  logic [ADDR_WIDTH-1:0] addr_q, addr_nxt;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_nxt;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_nxt;
  logic [CNT_W-1:0]      to_cnt, to_cnt_nxt;
  logic [RTY_W-1:0]      rtry, rtry_nxt;
  logic                  rearm, rearm_nxt;
  logic [CMD_W-1:0]      fifo_dat;
  logic                  fifo_full, fifo_empty, fifo_pop;
  logic                  rd_capture, retries_left;

  abus_sync_fifo #(.WIDTH(CMD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (abus_clk),
    .rst      (abus_rst),
    .push     (bus.cmd_valid && !fifo_full),
    .push_dat ({bus.cmd_write, bus.cmd_addr, bus.cmd_wdata}),
    .pop      (fifo_pop),
    .pop_dat  (fifo_dat),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign rd_capture   = !wr_q && bus.mst_new_rdata;
  assign retries_left = RETRY_EN && (rtry < RTY_W'(MAX_RETRY));

  always_comb begin
    state_nxt  = state;
    status_nxt = status_q;
    wr_nxt     = wr_q;
    addr_nxt   = addr_q;
    wdata_nxt  = wdata_q;
    rdata_nxt  = rdata_q;
    to_cnt_nxt = to_cnt;
    rtry_nxt   = rtry;
    rearm_nxt  = 1'b0;
    fifo_pop   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          {wr_nxt, addr_nxt, wdata_nxt} = fifo_dat;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        to_cnt_nxt = '0;
        rdata_nxt  = '0;
        state_nxt  = ST_WAIT;
      end
      // Counter is 0 in the first WAIT cycle, so the abort pulse lands TIMEOUT cycles after issue.
      ST_WAIT: begin
        to_cnt_nxt = to_cnt + CNT_W'(1);
        if (rd_capture) rdata_nxt = bus.mst_rdata;
        if (bus.mst_done) begin
          status_nxt = done_status(rtry != '0);
          state_nxt  = ST_RESP;
        end else if (to_cnt == CNT_W'(TIMEOUT - 2)) begin
          state_nxt = ST_ABORT;
        end
      end
      ST_ABORT: begin
        if (rd_capture) rdata_nxt = bus.mst_rdata;
        if (bus.mst_done) begin
          status_nxt = done_status(rtry != '0);
          state_nxt  = ST_RESP;
        end else begin
          state_nxt = ST_ABWAIT;
        end
      end
      // rearm holds one extra cycle so the master is back in idle before the re-issue.
      ST_ABWAIT: begin
        if (rearm) begin
          state_nxt = ST_ISSUE;
        end else if (bus.mst_done) begin
          if (retries_left) begin
            rtry_nxt  = rtry + RTY_W'(1);
            rearm_nxt = 1'b1;
          end else begin
            status_nxt = RSP_TIMEOUT;
            rdata_nxt  = '0;
            state_nxt  = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          rtry_nxt  = '0;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge abus_clk) begin
    if (abus_rst) begin
      state    <= ST_IDLE;
      status_q <= RSP_OK;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      to_cnt   <= '0;
      rtry     <= '0;
      rearm    <= 1'b0;
    end else begin
      state    <= state_nxt;
      status_q <= status_nxt;
      wr_q     <= wr_nxt;
      addr_q   <= addr_nxt;
      wdata_q  <= wdata_nxt;
      rdata_q  <= rdata_nxt;
      to_cnt   <= to_cnt_nxt;
      rtry     <= rtry_nxt;
      rearm    <= rearm_nxt;
    end
  end

  assign bus.cmd_ready   = !fifo_full;
  assign bus.mst_write   = (state == ST_ISSUE) && wr_q;
  assign bus.mst_read    = (state == ST_ISSUE) && !wr_q;
  assign bus.mst_abort   = (state == ST_ABORT);
  assign bus.mst_address = addr_q;
  assign bus.mst_wdata   = wdata_q;
  assign bus.rsp_valid   = (state == ST_RESP);
  assign bus.rsp_status  = status_q;
  assign bus.rsp_rdata   = rdata_q;

endmodule

// File: tb/tb_abus_cmd_queue.sv
// Directed bench for abus_cmd_queue: a behavioural abus master plus a response scoreboard.
module tb_abus_cmd_queue;
  import abus_cmd_queue_pkg::*;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam logic [DW-1:0] RD_KEY = 16'h1274;
`ifdef ABUS_CMD_QUEUE_RETRY_EN
  localparam int EXP_TRIES = 3;
`else
  localparam int EXP_TRIES = 1;
`endif

  logic abus_clk = 1'b0;
  logic abus_rst;
  always #5 abus_clk = ~abus_clk;

  abus_cmd_queue_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  abus_cmd_queue #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(4), .TIMEOUT(64), .MAX_RETRY(2)
  ) dut (
    .abus_clk (abus_clk),
    .abus_rst (abus_rst),
    .bus      (bus.slave)
  );

  int cyc = 0;
  always @(posedge abus_clk) cyc <= cyc + 1;

  // Master model: read data is address ^ RD_KEY; ack_delay 0 means never ack an order.
  int ack_delay = 3, abort_resp = 2, fail_attempts = 0;
  int cd = 0, att = 0, n_orders = 0, n_writes = 0, n_reads = 0, n_aborts = 0;
  int last_issue = 0, last_abort_gap = 0, last_done = -10, proto_err = 0;
  bit fire;
  logic          cur_read = 1'b0;
  logic [AW-1:0] last_addr = '0;
  logic [DW-1:0] last_wdata = '0;

  always @(negedge abus_clk) begin
    fire = 1'b0;
    bus.mst_done = 1'b0;
    bus.mst_new_rdata = 1'b0;
    bus.mst_rdata = '0;
    if (abus_rst) begin
      cd = 0;
      att = 0;
    end else begin
      if ((int'(bus.mst_write) + int'(bus.mst_read) + int'(bus.mst_abort)) > 1) proto_err++;
      if (bus.rsp_valid) att = 0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) fire = 1'b1;
      end
      if (bus.mst_write || bus.mst_read) begin
        if (last_done == cyc - 1) proto_err++;
        n_orders++;
        att++;
        if (bus.mst_write) n_writes++; else n_reads++;
        cur_read   = bus.mst_read;
        last_addr  = bus.mst_address;
        last_wdata = bus.mst_wdata;
        last_issue = cyc;
        cd = (ack_delay > 0 && att > fail_attempts) ? ack_delay : 0;
      end
      if (bus.mst_abort) begin
        n_aborts++;
        last_abort_gap = cyc - last_issue;
        if (abort_resp == 0) fire = 1'b1; else cd = abort_resp;
      end
      if (fire) begin
        bus.mst_done = 1'b1;
        last_done = cyc;
        if (cur_read) begin
          bus.mst_new_rdata = 1'b1;
          bus.mst_rdata = last_addr ^ RD_KEY;
        end
      end
    end
  end

  typedef struct packed {
    logic [1:0]    st;
    logic [DW-1:0] rd;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0, n_fail = 0;
  int acc_cyc = 0, rsp_cyc = 0;
  int b_w, b_r, b_ab, b_o;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [1:0] st, input logic [DW-1:0] rd, input bit track);
    int w = 0;
    while (!bus.cmd_ready && w < 200) begin
      @(negedge abus_clk);
      w++;
    end
    if (!bus.cmd_ready) check("push_wait", 32'(bus.cmd_ready), 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    acc_cyc = cyc;
    if (track) sb.push_back('{st: st, rd: rd});
    @(negedge abus_clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic get_rsp(input string tag);
    int w = 0;
    exp_t e;
    while (!bus.rsp_valid && w < 400) begin
      @(negedge abus_clk);
      w++;
    end
    rsp_cyc = cyc;
    check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 1);
    if (bus.rsp_valid) begin
      if (sb.size() == 0) begin
        check({tag, "_sb_size"}, sb.size(), 1);
      end else begin
        e = sb.pop_front();
        check({tag, "_status"}, 32'(bus.rsp_status), 32'(e.st));
        check({tag, "_rdata"}, 32'(bus.rsp_rdata), 32'(e.rd));
      end
      bus.rsp_ready = 1'b1;
      @(negedge abus_clk);
      bus.rsp_ready = 1'b0;
      check({tag, "_rsp_drop"}, 32'(bus.rsp_valid), 0);
    end
  endtask

  initial begin
    logic [AW-1:0] a;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0;
    abus_rst = 1'b1;
    repeat (3) @(negedge abus_clk);
    check("rst_cmd_ready", 32'(bus.cmd_ready), 1);
    check("rst_ctrl", 32'({bus.rsp_valid, bus.mst_write, bus.mst_read, bus.mst_abort,
                           bus.rsp_status, bus.rsp_rdata}), 0);
    check("rst_mst_bus", {bus.mst_address, bus.mst_wdata}, 0);
    abus_rst = 1'b0;
    @(negedge abus_clk);

    // Plain write, done 3 cycles after the order
    b_w = n_writes; b_r = n_reads;
    send_cmd(1'b1, 16'h0012, 16'hBEEF, RSP_OK, 16'h0000, 1'b1);
    get_rsp("wr");
    check("wr_latency", rsp_cyc - acc_cyc, 6);
    check("wr_pulses", n_writes - b_w, 1);
    check("wr_no_read", n_reads - b_r, 0);
    check("wr_addr", 32'(last_addr), 32'h0012);
    check("wr_wdata", 32'(last_wdata), 32'hBEEF);

    // Plain read
    ack_delay = 2;
    b_r = n_reads;
    send_cmd(1'b0, 16'h0040, 16'h0000, RSP_OK, 16'h1234, 1'b1);
    get_rsp("rd");
    check("rd_pulses", n_reads - b_r, 1);
    check("rd_addr", 32'(last_addr), 32'h0040);

    // Back-pressure: responses held, FIFO fills, then drain in order
    for (int i = 0; i < 5; i++) begin
      a = AW'(16'h0100 + i);
      send_cmd(a[0], a, DW'(16'h1000 + i), RSP_OK, a[0] ? 16'h0000 : (a ^ RD_KEY), 1'b1);
    end
    repeat (15) @(negedge abus_clk);
    check("bp_full", 32'(bus.cmd_ready), 0);
    check("bp_held", 32'(bus.rsp_valid), 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 16'h0FFF;
    repeat (3) @(negedge abus_clk);
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 5; i++) get_rsp("bp");
    repeat (20) @(negedge abus_clk);
    check("bp_no_extra", 32'(bus.rsp_valid), 0);

    // Timeout: master never acks the order, acks the abort two cycles later
    ack_delay = 0;
    abort_resp = 2;
    b_w = n_writes; b_ab = n_aborts;
    send_cmd(1'b1, 16'h0077, 16'h5555, RSP_TIMEOUT, 16'h0000, 1'b1);
    get_rsp("to");
    check("to_abort_gap", last_abort_gap, 64);
    check("to_writes", n_writes - b_w, EXP_TRIES);
    check("to_aborts", n_aborts - b_ab, EXP_TRIES);

    // Done arrives in the abort cycle itself
    abort_resp = 0;
    b_r = n_reads; b_ab = n_aborts;
    send_cmd(1'b0, 16'h0033, 16'h0000, RSP_OK, 16'h0033 ^ RD_KEY, 1'b1);
    get_rsp("race");
    check("race_reads", n_reads - b_r, 1);
    check("race_aborts", n_aborts - b_ab, 1);

`ifdef ABUS_CMD_QUEUE_RETRY_EN
    // First attempt times out, second is acked
    ack_delay = 2;
    abort_resp = 2;
    fail_attempts = 1;
    b_r = n_reads;
    send_cmd(1'b0, 16'h0099, 16'h0000, RSP_RETRIED_OK, 16'h0099 ^ RD_KEY, 1'b1);
    get_rsp("retry");
    check("retry_reads", n_reads - b_r, 2);
    fail_attempts = 0;
`endif

    // Reset while a transfer sits in WAIT with a second command queued
    ack_delay = 0;
    abort_resp = 2;
    b_o = n_orders;
    send_cmd(1'b1, 16'h0200, 16'hCAFE, RSP_OK, 16'h0000, 1'b0);
    send_cmd(1'b0, 16'h0201, 16'h0000, RSP_OK, 16'h0000, 1'b0);
    repeat (3) @(negedge abus_clk);
    check("mid_issued", n_orders - b_o, 1);
    abus_rst = 1'b1;
    @(negedge abus_clk);
    check("mid_rst_ctrl", 32'({bus.rsp_valid, bus.mst_write, bus.mst_read, bus.mst_abort,
                               bus.rsp_status, bus.rsp_rdata}), 0);
    check("mid_rst_bus", {bus.mst_address, bus.mst_wdata}, 0);
    check("mid_rst_ready", 32'(bus.cmd_ready), 1);
    abus_rst = 1'b0;
    repeat (15) @(negedge abus_clk);
    check("mid_fifo_empty", n_orders - b_o, 1);
    check("mid_no_rsp", 32'(bus.rsp_valid), 0);

    ack_delay = 3;
    send_cmd(1'b1, 16'h0300, 16'h0F0F, RSP_OK, 16'h0000, 1'b1);
    get_rsp("post_rst");

    check("protocol", proto_err, 0);
    check("sb_left", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
